// File: rtl/i_meas_seq_if.sv
// Bundle of request/ack, digitizer and result signals for the shared current-measurement channel.
// The sequencer takes the slave side; the controller/analog model takes the master side.
interface i_meas_seq_if #(
  parameter int N_CH     = 4,
  parameter int CODE_W   = 10,
  parameter int AVG_LOG2 = 2
);
  localparam int RES_W = CODE_W + 1 + AVG_LOG2;
  localparam int CH_W  = $clog2(N_CH);

  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   ack;
  logic [N_CH-1:0]   sel_onehot;
  logic              term_en;
  logic              adc_start;
  logic              adc_done;
  logic [CODE_W-1:0] adc_code;
  logic [CODE_W-1:0] ref_code;
  logic [RES_W-1:0]  result;
  logic [CH_W-1:0]   result_ch;
  logic              result_valid;
  logic              err;
  logic              busy;

  modport slave (
    input  req, adc_done, adc_code, ref_code,
    output ack, sel_onehot, term_en, adc_start, result, result_ch, result_valid, err, busy
  );

  modport master (
    output req, adc_done, adc_code, ref_code,
    input  ack, sel_onehot, term_en, adc_start, result, result_ch, result_valid, err, busy
  );
endinterface

// File: rtl/i_meas_seq.sv
// Round-robin sequencer sharing one I-V termination + digitizer among N_CH requesters:
// route, settle, accumulate 2^AVG_LOG2 offset conversions, return a signed tagged sum.
module i_meas_seq #(
  parameter int N_CH       = 4,
  parameter int CODE_W     = 10,
  parameter int AVG_LOG2   = 2,
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rstb,
  i_meas_seq_if.slave  bus
);
  localparam int RES_W = CODE_W + 1 + AVG_LOG2;
  localparam int CH_W  = $clog2(N_CH);
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int NSAMP = 1 << AVG_LOG2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]              state_reg, state_next;
  logic [CH_W-1:0]         ch_reg, last_reg;
  logic [7:0]              settle_reg;
  logic [15:0]             tmo_reg;
  logic [SMP_W-1:0]        smp_reg;
  logic signed [RES_W-1:0] acc_reg, result_reg;
  logic [CH_W-1:0]         result_ch_reg;
  logic                    err_reg;

  logic signed [CODE_W:0]  diff;
  logic signed [RES_W-1:0] diff_ext, acc_sum;
  logic                    last_smp, tmo_hit, settle_end;

  // Difference taken one bit wider so codes below the reference go negative.
  assign diff     = signed'({1'b0, bus.adc_code} - {1'b0, bus.ref_code});
  assign diff_ext = RES_W'(diff);
  assign acc_sum  = acc_reg + diff_ext;

  assign last_smp   = (smp_reg == SMP_W'(NSAMP - 1));
  assign tmo_hit    = (tmo_reg == 16'(TIMEOUT - 1));
  assign settle_end = (settle_reg == 8'(SETTLE_CYC - 1));

  // Candidate gi is the channel gi+1 places after the last grant.
  logic [CH_W-1:0] cand [N_CH];
  logic [N_CH-1:0] hit;
  logic [CH_W-1:0] pick;
  logic            pick_valid;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rr
      assign cand[gi] = CH_W'((int'(last_reg) + 1 + gi) % N_CH);
      assign hit[gi]  = bus.req[cand[gi]];
    end
  endgenerate

  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (hit[k]) begin
        pick       = cand[k];
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_valid) state_next = SETTLE;
      SETTLE:  if (settle_end) state_next = START;
      START:   state_next = WAIT;
      WAIT: begin
        if (bus.adc_done) state_next = last_smp ? DONE : START;
        else if (tmo_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg     <= IDLE;
      ch_reg        <= '0;
      last_reg      <= CH_W'(N_CH - 1);
      settle_reg    <= '0;
      tmo_reg       <= '0;
      smp_reg       <= '0;
      acc_reg       <= '0;
      result_reg    <= '0;
      result_ch_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            ch_reg     <= pick;
            last_reg   <= pick;
            settle_reg <= '0;
            smp_reg    <= '0;
            acc_reg    <= '0;
          end
        end
        SETTLE: settle_reg <= settle_reg + 8'd1;
        START:  tmo_reg <= '0;
        WAIT: begin
          // The result is captured on the way into DONE so it is visible during DONE.
          if (bus.adc_done) begin
            acc_reg <= acc_sum;
            smp_reg <= smp_reg + SMP_W'(1);
            if (last_smp) begin
              result_reg    <= acc_sum;
              result_ch_reg <= ch_reg;
              err_reg       <= 1'b0;
            end
          end else begin
            tmo_reg <= tmo_reg + 16'd1;
            if (tmo_hit) begin
              result_reg    <= acc_reg;
              result_ch_reg <= ch_reg;
              err_reg       <= 1'b1;
            end
          end
        end
        DONE:    acc_reg <= '0;
        default: ;
      endcase
    end
  end

  logic            routed;
  logic [N_CH-1:0] ch_onehot;

  assign routed    = (state_reg == SETTLE) || (state_reg == START) || (state_reg == WAIT);
  assign ch_onehot = N_CH'(1) << ch_reg;

  assign bus.sel_onehot   = routed ? ch_onehot : '0;
  assign bus.term_en      = routed;
  assign bus.adc_start    = (state_reg == START);
  assign bus.ack          = (state_reg == DONE) ? ch_onehot : '0;
  assign bus.result_valid = (state_reg == DONE);
  assign bus.busy         = (state_reg != IDLE);
  assign bus.result       = result_reg;
  assign bus.result_ch    = result_ch_reg;
  assign bus.err          = err_reg;
endmodule
